// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_ctrl
//  Purpose  : Command-decoding RAM behind an SPI slave. Each rx_valid word
//             {cmd[1:0], payload} loads the write address, writes data,
//             loads the read address or launches a read whose result is
//             returned on dout/tx_valid.
//  Options  : SPI_RAM_AUTOINC_EN - post-increment wr_addr after WR_DATA and
//             rd_addr after RD_DATA (modulo 2**ADDR_SIZE).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam int                 c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] c_DEPTH_EXT = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [1:0]         c_WR_ADDR   = 2'b00;
  localparam logic [1:0]         c_WR_DATA   = 2'b01;
  localparam logic [1:0]         c_RD_ADDR   = 2'b10;
  localparam logic [1:0]         c_RD_DATA   = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ARMED = 2'd1,
    RD_TX    = 2'd2
  } rd_state_t;

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

  rd_state_t            rd_state_q;
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic [ADDR_SIZE-1:0] dout_q;
  logic                 tx_valid_q;
  logic                 cmd_err_q;

  logic [1:0]           w_cmd;
  logic [ADDR_SIZE-1:0] w_payload;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic [ADDR_SIZE-1:0] w_wr_addr_d;
  logic [ADDR_SIZE-1:0] w_rd_addr_d;
  logic [ADDR_SIZE-1:0] w_rd_word;

  assign w_cmd     = din[ADDR_SIZE+1:ADDR_SIZE];
  assign w_payload = din[ADDR_SIZE-1:0];

  // Range checks only bite when the array is smaller than the address space
  assign w_wr_in_range = ({1'b0, wr_addr_q} < c_DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, rd_addr_q} < c_DEPTH_EXT);
  assign w_rd_word     = w_rd_in_range ? mem[rd_addr_q[c_IDX_W-1:0]] : '0;

`ifdef SPI_RAM_AUTOINC_EN
  // Post-increment pointers; wraps naturally at 2**ADDR_SIZE
  assign w_wr_addr_d = wr_addr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  assign w_rd_addr_d = rd_addr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
`else
  assign w_wr_addr_d = wr_addr_q;
  assign w_rd_addr_d = rd_addr_q;
`endif

  // Array write port: in-range WR_DATA only, contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && (w_cmd == c_WR_DATA) && w_wr_in_range) begin
      mem[wr_addr_q[c_IDX_W-1:0]] <= w_payload;
    end
  end

  // Command decode, address pointers, read FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else if (rx_valid) begin
      // Any accepted word drops tx_valid unless it is itself a read
      tx_valid_q <= 1'b0;
      case (w_cmd)
        c_WR_ADDR: begin
          wr_addr_q <= w_payload;
          if (rd_state_q == RD_TX) rd_state_q <= RD_ARMED;
        end
        c_WR_DATA: begin
          if (!w_wr_in_range) cmd_err_q <= 1'b1;
          wr_addr_q <= w_wr_addr_d;
          if (rd_state_q == RD_TX) rd_state_q <= RD_ARMED;
        end
        c_RD_ADDR: begin
          rd_addr_q  <= w_payload;
          rd_state_q <= RD_ARMED;
        end
        default: begin
          tx_valid_q <= 1'b1;
          rd_addr_q  <= w_rd_addr_d;
          if (rd_state_q == RD_IDLE) begin
            // Read without a prior RD_ADDR: return zero and flag it
            dout_q    <= '0;
            cmd_err_q <= 1'b1;
          end else begin
            dout_q     <= w_rd_word;
            rd_state_q <= RD_TX;
            if (!w_rd_in_range) cmd_err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_ctrl
//  Purpose  : Self-checking bench for spi_ram_ctrl. Drives a full-depth
//             instance (256) and a half-depth instance (128) with the same
//             words and compares both against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout_b, dout_s;
  logic       txv_b, txv_s, err_b, err_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_b), .tx_valid(txv_b), .cmd_err(err_b));

  spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_s), .tx_valid(txv_s), .cmd_err(err_s));

  // Behavioural model: index 0 = depth 256, index 1 = depth 128
  int         depth [2] = '{256, 128};
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_wa [2], m_ra [2];
  bit         m_armed [2], m_txv [2], m_err [2], m_dknown [2];
  logic [7:0] m_dout [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_armed[i] = 0;
      m_txv[i] = 0; m_err[i] = 0; m_dout[i] = 8'h00; m_dknown[i] = 1;
    end
  endtask

  task automatic model_word(input logic [1:0] c, input logic [7:0] p);
    for (int i = 0; i < 2; i++) begin
      m_txv[i] = 0;
      case (c)
        2'd0: m_wa[i] = p;
        2'd1: begin
          if (m_wa[i] < depth[i]) begin
            m_mem[i][m_wa[i]] = p; m_known[i][m_wa[i]] = 1;
          end else m_err[i] = 1;
`ifdef SPI_RAM_AUTOINC_EN
          m_wa[i] = (m_wa[i] + 1) % 256;
`endif
        end
        2'd2: begin m_ra[i] = p; m_armed[i] = 1; end
        default: begin
          m_txv[i] = 1;
          if (!m_armed[i] || m_ra[i] >= depth[i]) begin
            m_dout[i] = 8'h00; m_dknown[i] = 1; m_err[i] = 1;
          end else begin
            m_dout[i] = m_mem[i][m_ra[i]]; m_dknown[i] = m_known[i][m_ra[i]];
          end
`ifdef SPI_RAM_AUTOINC_EN
          m_ra[i] = (m_ra[i] + 1) % 256;
`endif
        end
      endcase
    end
  endtask

  // Present one word for one cycle; the model follows at the same edge
  task automatic drive(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    din = {c, p}; rx_valid = 1'b1;
    @(posedge clk);
    model_word(c, p);
    #1;
  endtask

  task automatic gap();
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reset with garbage words on din/rx_valid, which must be ignored
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      rx_valid = 1'($urandom); din = 10'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    model_reset();
    rst_n = 1'b1; rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (dout_b !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h exp 00", dout_b); end
    checks++; if (txv_b !== 1'b0)   begin errors++; $display("FAIL reset_txv: got %b exp 0", txv_b); end
    checks++; if (err_b !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b exp 0", err_b); end
    checks++; if ({dout_s, txv_s, err_s} !== 10'h0) begin errors++; $display("FAIL reset_small: got %h exp 000", {dout_s, txv_s, err_s}); end
  endtask

  task automatic test_basic_rw();
    do_reset();
    drive(2'd0, 8'h12); drive(2'd1, 8'hA5); drive(2'd2, 8'h12); drive(2'd3, 8'h00);
    checks++; if (dout_b !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h exp a5", dout_b); end
    checks++; if (txv_b !== 1'b1)   begin errors++; $display("FAIL basic_txv: got %b exp 1", txv_b); end
    checks++; if (err_b !== 1'b0)   begin errors++; $display("FAIL basic_err: got %b exp 0", err_b); end
    checks++; if (dout_s !== m_dout[1]) begin errors++; $display("FAIL basic_small_dout: got %h exp %h", dout_s, m_dout[1]); end
    gap();
  endtask

  task automatic test_read_idle();
    do_reset();
    drive(2'd3, 8'($urandom));
    checks++; if ({dout_b, txv_b, err_b} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL idle_read: got %h exp 003", {dout_b, txv_b, err_b}); end
    drive(2'd0, 8'h01); drive(2'd2, 8'h01); drive(2'd1, 8'h44); gap(); gap();
    checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err_b); end
    do_reset();
    #1;
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL err_clear_on_reset: got %b exp 0", err_b); end
  endtask

  task automatic test_tx_clear();
    do_reset();
    drive(2'd0, 8'h10); drive(2'd1, 8'h3C); drive(2'd2, 8'h10); drive(2'd3, 8'h00);
    checks++; if ({dout_b, txv_b} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL txclr_read: got %h exp 79", {dout_b, txv_b}); end
    drive(2'd0, 8'h00);
    checks++; if (txv_b !== 1'b0)   begin errors++; $display("FAIL txclr_txv: got %b exp 0", txv_b); end
    checks++; if (dout_b !== 8'h3C) begin errors++; $display("FAIL txclr_dout_hold: got %h exp 3c", dout_b); end
    gap(); gap();
    checks++; if (dout_b !== 8'h3C) begin errors++; $display("FAIL txclr_dout_idle: got %h exp 3c", dout_b); end
  endtask

  task automatic test_autoinc();
    logic [7:0] e1, e2;
`ifdef SPI_RAM_AUTOINC_EN
    e1 = 8'h11; e2 = 8'h22;
`else
    e1 = 8'h22; e2 = 8'h22;
`endif
    do_reset();
    drive(2'd0, 8'hFF); drive(2'd1, 8'h11); drive(2'd1, 8'h22);
    drive(2'd2, 8'hFF); drive(2'd3, 8'h00);
    checks++; if (dout_b !== e1) begin errors++; $display("FAIL autoinc_rd1: got %h exp %h", dout_b, e1); end
    drive(2'd3, 8'h00);
    checks++; if (dout_b !== e2) begin errors++; $display("FAIL autoinc_rd2: got %h exp %h", dout_b, e2); end
    checks++; if (txv_b !== 1'b1) begin errors++; $display("FAIL autoinc_txv: got %b exp 1", txv_b); end
    gap();
  endtask

  task automatic test_out_of_range();
    do_reset();
    drive(2'd0, 8'h00); drive(2'd1, 8'h77);
    drive(2'd0, 8'h80); drive(2'd1, 8'h5A);
    checks++; if ({err_s, err_b} !== 2'b10) begin errors++; $display("FAIL oor_wr_err: got %b exp 10", {err_s, err_b}); end
    drive(2'd2, 8'h80); drive(2'd3, 8'h00);
    checks++; if ({dout_s, txv_s, err_s} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL oor_rd_small: got %h exp 003", {dout_s, txv_s, err_s}); end
    checks++; if (dout_b !== 8'h5A) begin errors++; $display("FAIL oor_rd_big: got %h exp 5a", dout_b); end
    drive(2'd2, 8'h00); drive(2'd3, 8'h00);
    checks++; if (dout_s !== 8'h77) begin errors++; $display("FAIL oor_mem0_intact: got %h exp 77", dout_s); end
    gap();
  endtask

  task automatic test_same_addr();
    logic [7:0] a, d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom_range(0, 127)); d = 8'($urandom);
      drive(2'd2, a); drive(2'd0, a); drive(2'd1, d); drive(2'd3, 8'h00);
      checks++; if (dout_b !== d) begin errors++; $display("FAIL same_addr_big: got %h exp %h", dout_b, d); end
      checks++; if (dout_s !== d) begin errors++; $display("FAIL same_addr_small: got %h exp %h", dout_s, d); end
    end
    gap();
  endtask

  task automatic test_reset_during_tx();
    do_reset();
    drive(2'd0, 8'h05); drive(2'd1, 8'hC3); drive(2'd2, 8'h05); drive(2'd3, 8'h00);
    checks++; if ({dout_b, txv_b} !== {8'hC3, 1'b1}) begin errors++; $display("FAIL rsttx_pre: got %h exp 187", {dout_b, txv_b}); end
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    checks++; if ({dout_b, txv_b, err_b} !== 10'h000) begin errors++; $display("FAIL rsttx_outputs: got %h exp 000", {dout_b, txv_b, err_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd3, 8'h00);
    checks++; if ({dout_b, txv_b, err_b} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL rsttx_read_after: got %h exp 003", {dout_b, txv_b, err_b}); end
    gap();
  endtask

  // Fill the whole array, then random back-to-back traffic with random gaps
  task automatic test_back_to_back();
    logic [1:0] c;
    logic [7:0] p;
    for (int a = 0; a < 256; a++) begin
      drive(2'd0, 8'(a)); drive(2'd1, 8'($urandom));
    end
    do_reset();
    for (int n = 0; n < 400; n++) begin
      c = 2'($urandom); p = 8'($urandom);
      if (c == 2'd0 && ($urandom % 2) == 0) c = 2'd3;
      drive(c, p);
      checks++;
      if (txv_b !== m_txv[0] || err_b !== m_err[0] || (m_dknown[0] && dout_b !== m_dout[0])) begin
        errors++; $display("FAIL b2b_big word %0d cmd %0d: got d=%h v=%b e=%b exp d=%h v=%b e=%b", n, c, dout_b, txv_b, err_b, m_dout[0], m_txv[0], m_err[0]);
      end
      checks++;
      if (txv_s !== m_txv[1] || err_s !== m_err[1] || (m_dknown[1] && dout_s !== m_dout[1])) begin
        errors++; $display("FAIL b2b_small word %0d cmd %0d: got d=%h v=%b e=%b exp d=%h v=%b e=%b", n, c, dout_s, txv_s, err_s, m_dout[1], m_txv[1], m_err[1]);
      end
      if ($urandom_range(0, 3) == 0) gap();
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    gap();
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) begin m_mem[i][a] = 8'h00; m_known[i][a] = 0; end
    model_reset();
    test_reset();
    test_basic_rw();
    test_read_idle();
    test_tx_clear();
    test_autoinc();
    test_out_of_range();
    test_same_addr();
    test_reset_during_tx();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
